// File: rtl/byte_frame_tx_pkg.sv
// Shared constants, state encoding and FIFO entry layout for byte_frame_tx.
// BYTE_FRAME_TX_FCS_EN adds the FCS state to the state encoding.
package byte_frame_tx_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int unsigned PREAMBLE_LEN  = 7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SFD  = 3'd2,
        ST_DATA = 3'd3,
`ifdef BYTE_FRAME_TX_FCS_EN
        ST_FCS  = 3'd6,
`endif
        ST_DROP = 3'd4,
        ST_IFG  = 3'd5
    } tx_state_t;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/byte_frame_tx_if.sv
// Upstream valid/ready byte stream with end-of-frame marker.
interface byte_frame_tx_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (output s_data, output s_valid, output s_last, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last, output s_ready);

endinterface

// File: rtl/byte_tx_fifo.sv
// Synchronous show-ahead FIFO of {last, data} entries; DEPTH must be a power of two.
module byte_tx_fifo
    import byte_frame_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr,
    input  fifo_entry_t i_wr_data,
    input  logic        i_rd,
    output fifo_entry_t o_rd_data,
    output logic        o_full,
    output logic        o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fifo_entry_t   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_wr;
    logic          w_rd;

    // A write on a full FIFO is only legal when a pop frees the slot in the same cycle.
    assign w_rd      = i_rd && !o_empty;
    assign w_wr      = i_wr && (!o_full || w_rd);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_rd_data = r_mem[r_rd_ptr];

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/byte_frame_tx.sv
// Byte-stream frame transmitter: buffers payload, sends preamble/SFD/payload, then an IFG.
// Define BYTE_FRAME_TX_FCS_EN to append an XOR FCS byte after each complete frame.
module byte_frame_tx
    import byte_frame_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic             clk,
    input  logic             rst,
    byte_frame_tx_if.slave   s_if,
    output logic [7:0]       txd,
    output logic             tx_en,
    output logic             busy,
    output logic             frame_done,
    output logic             underrun
);

    localparam int unsigned FC_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CNT_MAX = (IFG_CYCLES > PREAMBLE_LEN) ? IFG_CYCLES : PREAMBLE_LEN;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    tx_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [FC_W-1:0] r_frm_cnt;
    logic [7:0]      r_txd;
    logic            r_tx_en;
    logic            r_frame_done;
    logic            r_underrun;
`ifdef BYTE_FRAME_TX_FCS_EN
    logic [7:0]      r_fcs;
`endif

    fifo_entry_t     w_wr_data;
    fifo_entry_t     w_rd_data;
    logic            w_wr;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_start;

    assign s_if.s_ready = !w_full;
    assign w_wr         = s_if.s_valid && !w_full;
    assign w_wr_data    = '{last: s_if.s_last, data: s_if.s_data};
    assign w_pop        = ((r_state == ST_DATA) || (r_state == ST_DROP)) && !w_empty;
    // A full FIFO starts a frame without a buffered end so long frames cannot deadlock.
    assign w_start      = (r_frm_cnt != '0) || w_full;

    assign txd        = r_txd;
    assign tx_en      = r_tx_en;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = r_frame_done;
    assign underrun   = r_underrun;

    byte_tx_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr      (w_wr),
        .i_wr_data (w_wr_data),
        .i_rd      (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Count of complete frames (last-marked entries) held in the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frm_cnt <= '0;
        end else begin
            case ({w_wr && s_if.s_last, w_pop && w_rd_data.last})
                2'b10:   r_frm_cnt <= r_frm_cnt + 1'b1;
                2'b01:   r_frm_cnt <= r_frm_cnt - 1'b1;
                default: r_frm_cnt <= r_frm_cnt;
            endcase
        end
    end

    // Transmit FSM with registered link outputs; outputs default to idle every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_txd        <= '0;
            r_tx_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
`ifdef BYTE_FRAME_TX_FCS_EN
            r_fcs        <= '0;
`endif
        end else begin
            r_txd        <= '0;
            r_tx_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_PRE;
                        r_cnt   <= '0;
                    end
                end
                ST_PRE: begin
                    r_txd   <= PREAMBLE_BYTE;
                    r_tx_en <= 1'b1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(PREAMBLE_LEN - 1)) begin
                        r_state <= ST_SFD;
                    end
                end
                ST_SFD: begin
                    r_txd   <= SFD_BYTE;
                    r_tx_en <= 1'b1;
`ifdef BYTE_FRAME_TX_FCS_EN
                    r_fcs   <= '0;
`endif
                    r_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (!w_empty) begin
                        r_txd   <= w_rd_data.data;
                        r_tx_en <= 1'b1;
`ifdef BYTE_FRAME_TX_FCS_EN
                        r_fcs   <= r_fcs ^ w_rd_data.data;
                        if (w_rd_data.last) begin
                            r_state <= ST_FCS;
                        end
`else
                        if (w_rd_data.last) begin
                            r_frame_done <= 1'b1;
                            r_state      <= ST_IFG;
                            r_cnt        <= '0;
                        end
`endif
                    end else begin
                        // Source fell behind mid-frame: abort and flush the rest of it.
                        r_underrun <= 1'b1;
                        r_state    <= ST_DROP;
                    end
                end
`ifdef BYTE_FRAME_TX_FCS_EN
                ST_FCS: begin
                    r_txd        <= r_fcs;
                    r_tx_en      <= 1'b1;
                    r_frame_done <= 1'b1;
                    r_state      <= ST_IFG;
                    r_cnt        <= '0;
                end
`endif
                ST_DROP: begin
                    if (w_pop && w_rd_data.last) begin
                        r_state <= ST_IFG;
                        r_cnt   <= '0;
                    end
                end
                ST_IFG: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(IFG_CYCLES - 1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_frame_tx.sv
// Directed self-checking bench for byte_frame_tx (honours BYTE_FRAME_TX_FCS_EN).
module tb_byte_frame_tx;

`ifdef BYTE_FRAME_TX_FCS_EN
    localparam int FCS = 1;
`else
    localparam int FCS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] txd;
    logic       tx_en;
    logic       busy;
    logic       frame_done;
    logic       underrun;

    byte_frame_tx_if u_if ();

    byte_frame_tx #(
        .FIFO_DEPTH (16),
        .IFG_CYCLES (12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_if       (u_if),
        .txd        (txd),
        .tx_en      (tx_en),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Link monitor: records transmitted bytes, burst edges and pulses.
    logic [7:0] q_tx[$];
    int         q_rise[$];
    int         q_fall[$];
    int         n_under   = 0;
    int         n_done    = 0;
    logic [7:0] done_byte = 8'h00;
    logic       prev_en   = 1'b0;

    always @(negedge clk) begin
        if (tx_en === 1'b1) q_tx.push_back(txd);
        if (tx_en === 1'b1 && !prev_en) q_rise.push_back(cyc);
        if (tx_en !== 1'b1 && prev_en) q_fall.push_back(cyc);
        prev_en = (tx_en === 1'b1);
        if (underrun === 1'b1) n_under++;
        if (frame_done === 1'b1) begin
            n_done++;
            done_byte = txd;
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int last_wr  = 0;
    int n_stall  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        u_if.s_data  = d;
        u_if.s_valid = 1'b1;
        u_if.s_last  = l;
        while (u_if.s_ready !== 1'b1 && n < 500) begin
            n_stall++;
            n++;
            @(negedge clk);
        end
        if (n >= 500) chk("push_timeout", {31'd0, u_if.s_ready}, 1);
        last_wr = cyc + 1;
    endtask

    task automatic idle();
        @(negedge clk);
        u_if.s_valid = 1'b0;
        u_if.s_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(n_done >= target && busy === 1'b0) && n < 2000);
        chk({tag, "_done"}, {31'd0, (n_done >= target && busy === 1'b0)}, 1);
    endtask

    task automatic check_frame(input string tag, input int base, input logic [7:0] pl[$],
                               input int with_fcs);
        logic [7:0] fcs;
        logic [7:0] exp;
        int         n;
        fcs = 8'h00;
        n   = 8 + pl.size() + with_fcs;
        for (int k = 0; k < n; k++) begin
            if (k < 7) exp = 8'h55;
            else if (k == 7) exp = 8'hD5;
            else if (k < 8 + pl.size()) begin
                exp = pl[k-8];
                fcs = fcs ^ exp;
            end else exp = fcs;
            chk($sformatf("%s_b%0d", tag, k), {24'd0, q_tx[base+k]}, {24'd0, exp});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base, nb, d0, u0, w, w16, w20, n, s0;
        logic [7:0] pl[$];
        logic [7:0] pl2[$];

        u_if.s_data  = 8'h00;
        u_if.s_valid = 1'b0;
        u_if.s_last  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_txd", {24'd0, txd}, 0);
        chk("rst_tx_en", {31'd0, tx_en}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, frame_done}, 0);
        chk("rst_underrun", {31'd0, underrun}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", {31'd0, u_if.s_ready}, 1);
        chk("rst_busy_after", {31'd0, busy}, 0);

        // Basic 3-byte frame
        base = q_tx.size(); nb = q_rise.size(); d0 = n_done;
        push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h04, 1'b1);
        w = last_wr;
        idle();
        wait_done("t1", d0 + 1);
        chk("t1_start_latency", q_rise[nb] - w, 2);
        chk("t1_tx_en_len", q_fall[nb] - q_rise[nb], 11 + FCS);
        pl = {8'h01, 8'h02, 8'h04};
        check_frame("t1", base, pl, FCS);
        chk("t1_done_byte", {24'd0, done_byte}, (FCS != 0) ? 32'h07 : 32'h04);
        chk("t1_done_count", n_done - d0, 1);
        chk("t1_no_underrun", n_under, 0);

        // Two back-to-back 4-byte frames: exact IFG spacing
        base = q_tx.size(); nb = q_rise.size(); d0 = n_done;
        push(8'h10, 1'b0); push(8'h11, 1'b0); push(8'h12, 1'b0); push(8'h13, 1'b1);
        push(8'h20, 1'b0); push(8'h21, 1'b0); push(8'h22, 1'b0); push(8'h23, 1'b1);
        idle();
        wait_done("t2", d0 + 2);
        chk("t2_ifg_gap", q_rise[nb+1] - q_fall[nb], 13);
        chk("t2_len_a", q_fall[nb] - q_rise[nb], 12 + FCS);
        chk("t2_len_b", q_fall[nb+1] - q_rise[nb+1], 12 + FCS);
        pl = {8'h10, 8'h11, 8'h12, 8'h13};
        check_frame("t2a", base, pl, FCS);
        pl = {8'h20, 8'h21, 8'h22, 8'h23};
        check_frame("t2b", base + 12 + FCS, pl, FCS);

        // 20-byte frame with valid held: cut-through on full FIFO
        base = q_tx.size(); nb = q_rise.size(); d0 = n_done; u0 = n_under; s0 = n_stall;
        w16 = 0;
        pl.delete();
        for (int i = 0; i < 20; i++) begin
            push(8'(i), i == 19);
            if (i == 15) w16 = last_wr;
            pl.push_back(8'(i));
        end
        idle();
        wait_done("t3", d0 + 1);
        chk("t3_ready_dropped", {31'd0, (n_stall != s0)}, 1);
        chk("t3_full_start_latency", q_rise[nb] - w16, 2);
        chk("t3_cut_through", {31'd0, (q_rise[nb] < last_wr)}, 1);
        chk("t3_tx_en_len", q_fall[nb] - q_rise[nb], 28 + FCS);
        check_frame("t3", base, pl, FCS);
        chk("t3_no_underrun", n_under - u0, 0);

        // Underrun: 16 bytes, 40-cycle stall, 4 late bytes, then a 2-byte frame
        base = q_tx.size(); nb = q_rise.size(); d0 = n_done; u0 = n_under;
        pl.delete();
        for (int i = 0; i < 16; i++) begin
            push(8'hA0 + 8'(i), 1'b0);
            pl.push_back(8'hA0 + 8'(i));
        end
        idle();
        repeat (40) @(negedge clk);
        for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i), i == 3);
        w20 = last_wr;
        push(8'hE1, 1'b0); push(8'hE2, 1'b1);
        idle();
        wait_done("t4", d0 + 1);
        #1;
        chk("t4_underrun_once", n_under - u0, 1);
        chk("t4_abort_len", q_fall[nb] - q_rise[nb], 24);
        check_frame("t4_abort", base, pl, 0);
        pl2 = {8'hE1, 8'hE2};
        check_frame("t4_next", base + 24, pl2, FCS);
        chk("t4_next_start", q_rise[nb+1] - w20, 15);
        chk("t4_total_bytes", q_tx.size() - base, 34 + FCS);

        // Reset during payload byte 2
        base = q_tx.size(); nb = q_rise.size(); u0 = n_under;
        for (int i = 0; i < 5; i++) push(8'h71 + 8'(i), i == 4);
        idle();
        n = 0;
        while (q_tx.size() < base + 10 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t5_reach_byte2", {31'd0, (q_tx.size() >= base + 10)}, 1);
        chk("t5_byte2", {24'd0, q_tx[base+9]}, 32'h72);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_tx_en", {31'd0, tx_en}, 0);
        chk("t5_rst_txd", {24'd0, txd}, 0);
        chk("t5_rst_busy", {31'd0, busy}, 0);
        chk("t5_rst_ready", {31'd0, u_if.s_ready}, 1);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("t5_no_underrun", n_under - u0, 0);
        chk("t5_fifo_flushed", q_rise.size() - nb, 1);
        chk("t5_bytes_cut", q_tx.size() - base, 10);
        base = q_tx.size(); nb = q_rise.size(); d0 = n_done;
        push(8'h81, 1'b0); push(8'h82, 1'b0); push(8'h83, 1'b1);
        idle();
        wait_done("t5", d0 + 1);
        pl = {8'h81, 8'h82, 8'h83};
        check_frame("t5_new", base, pl, FCS);
        chk("t5_new_len", q_fall[nb] - q_rise[nb], 11 + FCS);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
